// File: rtl/gusn_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gusn_pkg
// Purpose  : Shared types and saturating fixed-point helpers for the dense
//            layer engine (mode / FSM encodings, clamp, add, multiply-shift).
//            All arithmetic helpers work on a 64-bit signed carrier and take
//            the target number width as an argument, so one package serves
//            every parameterisation with NUM_W up to 31 bits.
// Revision : 1.0  initial release
// ============================================================================
package gusn_pkg;

   typedef enum logic {
      MODE_FWD = 1'b0,
      MODE_BWD = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_INT_W  = 9;
   localparam int DEF_FRAC_W = 8;
   localparam int CALC_W     = 64;

   typedef logic signed [CALC_W-1:0] calc_t;

   // Largest positive value of a num_w-bit signed number.
   function automatic calc_t max_pos(input int num_w);
      return (calc_t'(1) <<< (num_w - 1)) - calc_t'(1);
   endfunction

   // Most negative value of a num_w-bit signed number.
   function automatic calc_t max_neg(input int num_w);
      return -(calc_t'(1) <<< (num_w - 1));
   endfunction

   function automatic calc_t sat_clamp(input calc_t v, input int num_w);
      if (v > max_pos(num_w)) return max_pos(num_w);
      if (v < max_neg(num_w)) return max_neg(num_w);
      return v;
   endfunction

   // Operands are already in range, so the wide carrier never wraps.
   function automatic calc_t sat_add(input calc_t a, input calc_t b, input int num_w);
      return sat_clamp(a + b, num_w);
   endfunction

   // Full-precision product, rescaled by frac, optional extra down-shift,
   // then clamped to the number range.
   function automatic calc_t sat_mul_shift(input calc_t a, input calc_t b,
                                           input int frac, input int shift,
                                           input int num_w);
      calc_t prod;
      prod = a * b;
      prod = prod >>> frac;
      prod = prod >>> shift;
      return sat_clamp(prod, num_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_mult.sv
`default_nettype none
// ============================================================================
// Module   : sat_mult
// Purpose  : One-clock registered multiply / rescale / saturate stage. The
//            column and row tags travel alongside the product.
// Ports    : clk, reset       clock, async active-high reset
//            in_valid         operands valid this cycle
//            in_a, in_b       signed fixed-point operands
//            in_shift_en      apply the extra RELU_SHIFT down-shift
//            in_col, in_row   element tags
//            out_valid/out_p/out_col/out_row   registered result and tags
// Revision : 1.0  initial release
// ============================================================================
module sat_mult
   import gusn_pkg::*;
#(
   parameter int NUM_W      = 17,
   parameter int FRAC_W     = 8,
   parameter int RELU_SHIFT = 4,
   parameter int COL_W      = 2,
   parameter int ROW_W      = 1
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic signed [NUM_W-1:0] in_a,
   input  logic signed [NUM_W-1:0] in_b,
   input  logic                    in_shift_en,
   input  logic [COL_W-1:0]        in_col,
   input  logic [ROW_W-1:0]        in_row,
   output logic                    out_valid,
   output logic signed [NUM_W-1:0] out_p,
   output logic [COL_W-1:0]        out_col,
   output logic [ROW_W-1:0]        out_row
);

   logic                    valid_q, valid_d;
   logic signed [NUM_W-1:0] p_q, p_d;
   logic [COL_W-1:0]        col_q, col_d;
   logic [ROW_W-1:0]        row_q, row_d;

   always_comb begin
      valid_d = in_valid;
      col_d   = in_col;
      row_d   = in_row;
      p_d     = NUM_W'(sat_mul_shift(calc_t'(in_a), calc_t'(in_b), FRAC_W,
                                     in_shift_en ? RELU_SHIFT : 0, NUM_W));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         p_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         valid_q <= valid_d;
         p_q     <= p_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   assign out_valid = valid_q;
   assign out_p     = p_q;
   assign out_col   = col_q;
   assign out_row   = row_q;

endmodule
`default_nettype wire

// File: rtl/sat_dense_engine.sv
`default_nettype none
// ============================================================================
// Module   : sat_dense_engine
// Purpose  : Serial saturating fixed-point dense layer. Walks one weight block
//            (row-major, bias last in each row) through a single RAM read
//            port and computes either the forward pass
//              res_f[i] = act(sum_j w[i][j]*x[j] + b[i])
//            or the backward pass
//              res_b[j] = sum_i (w[i][j]*d[i]) >>> (shift_in[i] ? RELU_SHIFT : 0)
//            with saturation after every multiply and every add.
// Ports    : clk, reset              clock, async active-high reset
//            enable, start, mode     pass launch (sampled in IDLE only)
//            vec_f, vec_b, shift_in  operand vectors, latched at start
//            ram_rd_en, ram_addr_read, ram_data_read   RAM read port
//            res_f, res_b            result banks, held until next same-mode start
//            diffshift_out           per-row pre-activation out of [0, RELU_MAX]
//            ready, done             handshake
// Revision : 1.0  initial release
// ============================================================================
module sat_dense_engine
   import gusn_pkg::*;
#(
   parameter int INT_W          = DEF_INT_W,
   parameter int FRAC_W         = DEF_FRAC_W,
   parameter int INPUTS         = 3,
   parameter int OUTPUTS        = 2,
   parameter int RAM_ADDR_W     = 8,
   parameter int RAM_ADDR_START = 0,
   parameter int RAM_DELAY      = 1,
   parameter int ACT            = 1,
   parameter int RELU_SHIFT     = 4,
   parameter int RELU_MAX       = 1
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                start,
   input  logic                                mode,
   input  logic [INPUTS*(INT_W+FRAC_W)-1:0]    vec_f,
   input  logic [OUTPUTS*(INT_W+FRAC_W)-1:0]   vec_b,
   input  logic [OUTPUTS-1:0]                  shift_in,
   output logic                                ram_rd_en,
   output logic [RAM_ADDR_W-1:0]               ram_addr_read,
   input  logic [INT_W+FRAC_W-1:0]             ram_data_read,
   output logic [OUTPUTS*(INT_W+FRAC_W)-1:0]   res_f,
   output logic [INPUTS*(INT_W+FRAC_W)-1:0]    res_b,
   output logic [OUTPUTS-1:0]                  diffshift_out,
   output logic                                ready,
   output logic                                done
);

   localparam int NUM_W = INT_W + FRAC_W;
   localparam int COL_W = $clog2(INPUTS + 1);
   localparam int ROW_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

   // Bias goes through the multiplier as bias * 1.0, which is exact.
   localparam logic signed [NUM_W-1:0] ONE_FX = NUM_W'(calc_t'(1) <<< FRAC_W);
   localparam calc_t CLIP_RAW = calc_t'(RELU_MAX) <<< FRAC_W;
   localparam calc_t CLIP_LIM = (CLIP_RAW > max_pos(NUM_W)) ? max_pos(NUM_W) : CLIP_RAW;

   // ---------------------------------------------------------------- state
   state_e                          state_q, state_d;
   mode_e                           mode_q, mode_d;
   logic [INPUTS*NUM_W-1:0]         vec_f_q, vec_f_d;
   logic [OUTPUTS*NUM_W-1:0]        vec_b_q, vec_b_d;
   logic [OUTPUTS-1:0]              shift_q, shift_d;
   logic [RAM_ADDR_W-1:0]           addr_q, addr_d;
   logic [COL_W-1:0]                col_q, col_d;
   logic [ROW_W-1:0]                row_q, row_d;
   logic [RAM_DELAY-1:0]            tag_v_q, tag_v_d;
   logic [COL_W-1:0]                tag_col_q [RAM_DELAY];
   logic [COL_W-1:0]                tag_col_d [RAM_DELAY];
   logic [ROW_W-1:0]                tag_row_q [RAM_DELAY];
   logic [ROW_W-1:0]                tag_row_d [RAM_DELAY];
   logic signed [NUM_W-1:0]         acc_q, acc_d;
   logic [OUTPUTS*NUM_W-1:0]        res_f_q, res_f_d;
   logic [INPUTS*NUM_W-1:0]         res_b_q, res_b_d;
   logic [OUTPUTS-1:0]              diff_q, diff_d;

   // ------------------------------------------------------ multiply stage
   logic signed [NUM_W-1:0]         mul_b;
   logic                            mul_shift_en;
   logic                            mul_v;
   logic signed [NUM_W-1:0]         mul_p;
   logic [COL_W-1:0]                mul_col;
   logic [ROW_W-1:0]                mul_row;
   calc_t                           acc_sum;
   calc_t                           act_val;

   // The oldest tag lines up with the RAM word arriving this cycle; pick
   // the second operand from its column (FWD) or row (BWD).
   always_comb begin
      mul_b        = ONE_FX;
      mul_shift_en = 1'b0;
      if (mode_q == MODE_FWD) begin
         for (int k = 0; k < INPUTS; k++) begin
            if (tag_col_q[RAM_DELAY-1] == COL_W'(k)) begin
               mul_b = vec_f_q[k*NUM_W +: NUM_W];
            end
         end
      end else begin
         for (int k = 0; k < OUTPUTS; k++) begin
            if (tag_row_q[RAM_DELAY-1] == ROW_W'(k)) begin
               mul_b        = vec_b_q[k*NUM_W +: NUM_W];
               mul_shift_en = shift_q[k];
            end
         end
      end
   end

   sat_mult #(
      .NUM_W      (NUM_W),
      .FRAC_W     (FRAC_W),
      .RELU_SHIFT (RELU_SHIFT),
      .COL_W      (COL_W),
      .ROW_W      (ROW_W)
   ) u_sat_mult (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (tag_v_q[RAM_DELAY-1]),
      .in_a        (ram_data_read),
      .in_b        (mul_b),
      .in_shift_en (mul_shift_en),
      .in_col      (tag_col_q[RAM_DELAY-1]),
      .in_row      (tag_row_q[RAM_DELAY-1]),
      .out_valid   (mul_v),
      .out_p       (mul_p),
      .out_col     (mul_col),
      .out_row     (mul_row)
   );

   // ------------------------------------------- next state and datapath
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      vec_f_d = vec_f_q;
      vec_b_d = vec_b_q;
      shift_d = shift_q;
      addr_d  = addr_q;
      col_d   = col_q;
      row_d   = row_q;
      acc_d   = acc_q;
      res_f_d = res_f_q;
      res_b_d = res_b_q;
      diff_d  = diff_q;

      // Valid/tag shift register, depth RAM_DELAY, fed by the read strobe.
      for (int k = 0; k < RAM_DELAY; k++) begin
         if (k == 0) begin
            tag_v_d[k]   = (state_q == ST_ISSUE);
            tag_col_d[k] = col_q;
            tag_row_d[k] = row_q;
         end else begin
            tag_v_d[k]   = tag_v_q[k-1];
            tag_col_d[k] = tag_col_q[k-1];
            tag_row_d[k] = tag_row_q[k-1];
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start && enable) begin
               state_d = ST_ISSUE;
               mode_d  = mode_e'(mode);
               vec_f_d = vec_f;
               vec_b_d = vec_b;
               shift_d = shift_in;
               addr_d  = RAM_ADDR_W'(RAM_ADDR_START);
               col_d   = '0;
               row_d   = '0;
               acc_d   = '0;
               if (mode == 1'b0) begin
                  res_f_d = '0;
                  diff_d  = '0;
               end else begin
                  res_b_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            addr_d = addr_q + RAM_ADDR_W'(1);
            if (col_q == COL_W'(INPUTS)) begin
               col_d = '0;
               row_d = row_q + ROW_W'(1);
               if (row_q == ROW_W'(OUTPUTS - 1)) begin
                  state_d = ST_DRAIN;
               end
            end else begin
               col_d = col_q + COL_W'(1);
            end
         end
         ST_DRAIN: begin
            if ((tag_v_q == '0) && !mul_v) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Accumulate stage: consumes one product per cycle.
      acc_sum = sat_add(calc_t'(acc_q), calc_t'(mul_p), NUM_W);
      if (ACT != 0) begin
         act_val = (acc_sum < 0) ? calc_t'(0) :
                   (acc_sum > CLIP_LIM) ? CLIP_LIM : acc_sum;
      end else begin
         act_val = acc_sum;
      end

      if (mul_v) begin
         if (mode_q == MODE_FWD) begin
            if (mul_col == COL_W'(INPUTS)) begin
               // Bias term closes the row: publish and restart the accumulator.
               acc_d = '0;
               for (int k = 0; k < OUTPUTS; k++) begin
                  if (mul_row == ROW_W'(k)) begin
                     diff_d[k] = (acc_sum > CLIP_RAW) || (acc_sum < 0);
                     res_f_d[k*NUM_W +: NUM_W] = NUM_W'(act_val);
                  end
               end
            end else begin
               acc_d = NUM_W'(acc_sum);
            end
         end else begin
            // Bias column matches no k here, so it is fetched but dropped.
            for (int k = 0; k < INPUTS; k++) begin
               if (mul_col == COL_W'(k)) begin
                  res_b_d[k*NUM_W +: NUM_W] = NUM_W'(sat_add(
                     calc_t'($signed(res_b_q[k*NUM_W +: NUM_W])),
                     calc_t'(mul_p), NUM_W));
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_FWD;
         vec_f_q   <= '0;
         vec_b_q   <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         col_q     <= '0;
         row_q     <= '0;
         tag_v_q   <= '0;
         tag_col_q <= '{default: '0};
         tag_row_q <= '{default: '0};
         acc_q     <= '0;
         res_f_q   <= '0;
         res_b_q   <= '0;
         diff_q    <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         vec_f_q   <= vec_f_d;
         vec_b_q   <= vec_b_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         col_q     <= col_d;
         row_q     <= row_d;
         tag_v_q   <= tag_v_d;
         tag_col_q <= tag_col_d;
         tag_row_q <= tag_row_d;
         acc_q     <= acc_d;
         res_f_q   <= res_f_d;
         res_b_q   <= res_b_d;
         diff_q    <= diff_d;
      end
   end

   assign ram_rd_en     = (state_q == ST_ISSUE);
   assign ram_addr_read = addr_q;
   assign res_f         = res_f_q;
   assign res_b         = res_b_q;
   assign diffshift_out = diff_q;
   assign ready         = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign done          = (state_q == ST_DONE);

endmodule
`default_nettype wire
